sp_ram_march_bist: RTL and testbench

//  Initiator-side March C- self-test engine for the single-port data/instr RAM wrapper.

---
 rtl/sp_ram_bist_pkg.sv | 59 +++++
 rtl/sp_ram_march_bist.sv | 171 +++++++++++++++++
 tb/tb_sp_ram_march_bist.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_bist_pkg.sv
// Shared types and per-element March C- constants for the RAM self-test engine.
// No logic; the sequencer in sp_ram_march_bist decodes these.
package sp_ram_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } march_elem_t;

  // has_rd: op0 is a read; two_ops: op1 is a write following that read.
  typedef struct packed {
    logic down;
    logic has_rd;
    logic two_ops;
    logic rd_bg;
    logic wr_bg;
  } elem_cfg_t;

  function automatic elem_cfg_t elem_cfg(input march_elem_t e);
    elem_cfg_t c;
    c = '0;
    case (e)
      M0:      c = '{down: 1'b0, has_rd: 1'b0, two_ops: 1'b0, rd_bg: 1'b0, wr_bg: 1'b0};
      M1:      c = '{down: 1'b0, has_rd: 1'b1, two_ops: 1'b1, rd_bg: 1'b0, wr_bg: 1'b1};
      M2:      c = '{down: 1'b0, has_rd: 1'b1, two_ops: 1'b1, rd_bg: 1'b1, wr_bg: 1'b0};
      M3:      c = '{down: 1'b1, has_rd: 1'b1, two_ops: 1'b1, rd_bg: 1'b0, wr_bg: 1'b1};
      M4:      c = '{down: 1'b1, has_rd: 1'b1, two_ops: 1'b1, rd_bg: 1'b1, wr_bg: 1'b0};
      M5:      c = '{down: 1'b1, has_rd: 1'b1, two_ops: 1'b0, rd_bg: 1'b0, wr_bg: 1'b0};
      default: c = '0;
    endcase
    return c;
  endfunction

  // Saturates at M5; the sequencer leaves RUN after the last M5 access.
  function automatic march_elem_t next_elem(input march_elem_t e);
    march_elem_t n;
    case (e)
      M0:      n = M1;
      M1:      n = M2;
      M2:      n = M3;
      M3:      n = M4;
      M4:      n = M5;
      default: n = M5;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sp_ram_march_bist.sv
// March C- self-test initiator for a single-port RAM with 1-cycle read latency.
// One access per cycle; done 10*NUM_WORDS+2 cycles after start; no backpressure from the RAM.
module sp_ram_march_bist
  import sp_ram_bist_pkg::*;
#(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic [ADDR_WIDTH-1:0]     fail_addr_o,
  output logic [DATA_WIDTH-1:0]     fail_data_o,
  output logic                      ram_en_o,
  output logic [ADDR_WIDTH-1:0]     ram_addr_o,
  output logic [DATA_WIDTH-1:0]     ram_wdata_o,
  output logic                      ram_we_o,
  output logic [DATA_WIDTH/8-1:0]   ram_be_o,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

  localparam int BE_W      = DATA_WIDTH / 8;
  localparam int NUM_WORDS = RAM_SIZE / BE_W;
  localparam int WORD_W    = $clog2(NUM_WORDS);
  localparam int BYTE_SH   = $clog2(BE_W);

  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(NUM_WORDS - 1);

  bist_state_t               state_q, state_d;
  march_elem_t               elem_q, elem_d;
  logic [WORD_W-1:0]         word_q, word_d;
  logic                      op_q, op_d;
  logic                      rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0]     rd_exp_q, rd_exp_d;
  logic [ADDR_WIDTH-1:0]     rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0]     fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0]     fail_data_q, fail_data_d;
  logic                      pass_q, pass_d;

  elem_cfg_t                 cfg;
  elem_cfg_t                 cfg_next;
  logic [ADDR_WIDTH-1:0]     word_addr;
  logic                      is_read;
  logic                      last_op;
  logic                      last_word;
  logic                      mismatch;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      elem_q      <= M0;
      word_q      <= '0;
      op_q        <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_exp_q    <= '0;
      rd_addr_q   <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      word_q      <= word_d;
      op_q        <= op_d;
      rd_vld_q    <= rd_vld_d;
      rd_exp_q    <= rd_exp_d;
      rd_addr_q   <= rd_addr_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    cfg       = elem_cfg(elem_q);
    cfg_next  = elem_cfg(next_elem(elem_q));
    word_addr = ADDR_WIDTH'(word_q) << BYTE_SH;
    is_read   = cfg.has_rd && !op_q;
    last_op   = !cfg.two_ops || op_q;
    last_word = cfg.down ? (word_q == '0) : (word_q == WORD_LAST);
    mismatch  = (state_q == RUN || state_q == DRAIN) && rd_vld_q && (ram_rdata_i != rd_exp_q);
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    word_d      = word_q;
    op_d        = op_q;
    rd_vld_d    = 1'b0;
    rd_exp_d    = rd_exp_q;
    rd_addr_d   = rd_addr_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    pass_d      = pass_q;
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d     = RUN;
          elem_d      = M0;
          word_d      = '0;
          op_d        = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end

      RUN: begin
        ram_en_o    = 1'b1;
        ram_be_o    = '1;
        ram_addr_o  = word_addr;
        ram_we_o    = !is_read;
        ram_wdata_o = is_read ? '0 : {DATA_WIDTH{cfg.wr_bg}};

        if (is_read) begin
          rd_vld_d  = 1'b1;
          rd_exp_d  = {DATA_WIDTH{cfg.rd_bg}};
          rd_addr_d = word_addr;
        end

        // Read/write pairs stay on one word; the word moves only after the last op.
        if (!last_op) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (!last_word) begin
            word_d = cfg.down ? (word_q - WORD_W'(1)) : (word_q + WORD_W'(1));
          end else if (elem_q == M5) begin
            state_d = DRAIN;
          end else begin
            elem_d = next_elem(elem_q);
            word_d = cfg_next.down ? WORD_LAST : '0;
          end
        end
      end

      DRAIN: begin
        state_d = DONE;
        pass_d  = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    // Only the first mismatch is ever latched: it moves the engine straight to DONE.
    if (mismatch) begin
      state_d     = DONE;
      rd_vld_d    = 1'b0;
      pass_d      = 1'b0;
      fail_addr_d = rd_addr_q;
      fail_data_d = ram_rdata_i;
    end
  end

  assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE);
  assign pass_o      = pass_q && done_o;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;

endmodule

// File: tb/tb_sp_ram_march_bist.sv
// Directed bench for sp_ram_march_bist: 16-word RAM model with stuck-at fault injection,
// vector table of runs plus hand sequences for restart, mid-run start and mid-run reset.
module tb_sp_ram_march_bist;

  localparam int RAM_SIZE = 64;
  localparam int AW       = 6;
  localparam int DW       = 32;
  localparam int NW       = 16;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            start_i;
  logic            busy_o, done_o, pass_o;
  logic [AW-1:0]   fail_addr_o;
  logic [DW-1:0]   fail_data_o;
  logic            ram_en_o;
  logic [AW-1:0]   ram_addr_o;
  logic [DW-1:0]   ram_wdata_o;
  logic            ram_we_o;
  logic [3:0]      ram_be_o;
  logic [DW-1:0]   ram_rdata_i;

  always #5 clk = ~clk;

  sp_ram_march_bist #(
    .RAM_SIZE  (RAM_SIZE),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pass_o     (pass_o),
    .fail_addr_o(fail_addr_o),
    .fail_data_o(fail_data_o),
    .ram_en_o   (ram_en_o),
    .ram_addr_o (ram_addr_o),
    .ram_wdata_o(ram_wdata_o),
    .ram_we_o   (ram_we_o),
    .ram_be_o   (ram_be_o),
    .ram_rdata_i(ram_rdata_i)
  );

  // RAM model: stuck-at faults applied on the read path of one word.
  logic [DW-1:0] mem [NW];
  int            f_word;
  logic [DW-1:0] f_and, f_or;

  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) mem[ram_addr_o[5:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end else if (int'(ram_addr_o[5:2]) == f_word) begin
        ram_rdata_i <= (mem[ram_addr_o[5:2]] & f_and) | f_or;
      end else begin
        ram_rdata_i <= mem[ram_addr_o[5:2]];
      end
    end
  end

  // Expected March C- access k (0..159) derived from the element table.
  function automatic void exp_acc(input int k, output logic [AW-1:0] a, output logic we,
                                  output logic [DW-1:0] wd);
    int w, j;
    if (k < 16) begin
      w = k; we = 1'b1; wd = '0;
    end else if (k < 80) begin
      j = (k - 16) % 32; w = j / 2; we = j[0]; wd = (k < 48) ? '1 : '0;
    end else if (k < 144) begin
      j = (k - 80) % 32; w = 15 - j / 2; we = j[0]; wd = (k < 112) ? '1 : '0;
    end else begin
      w = 15 - (k - 144); we = 1'b0; wd = '0;
    end
    a = AW'(w * 4);
  endfunction

  int            acc_total = 0;
  int            trace_err = 0;
  int            run_base  = 0;
  logic [AW-1:0] trace_addr [160];

  always @(negedge clk) begin
    int            k, e;
    logic [AW-1:0] ea;
    logic          ewe;
    logic [DW-1:0] ewd;
    e = 0;
    if (ram_addr_o[1:0] != 2'b00) e++;
    if (ram_en_o) begin
      k = acc_total - run_base;
      if (ram_be_o != 4'hF) e++;
      if (k < 160) begin
        exp_acc(k, ea, ewe, ewd);
        trace_addr[k] <= ram_addr_o;
        if (ram_addr_o != ea || ram_we_o != ewe) e++;
        if (ewe && ram_wdata_o != ewd) e++;
      end else begin
        e++;
      end
      acc_total <= acc_total + 1;
    end else if (ram_we_o) begin
      e++;
    end
    if (e != 0) begin
      trace_err <= trace_err + e;
      $display("[TB] trace deviation at access %0d addr=0x%0h we=%0b wdata=0x%0h be=0x%0h",
               acc_total - run_base, ram_addr_o, ram_we_o, ram_wdata_o, ram_be_o);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string         name;
    int            fword;
    logic [DW-1:0] and_m;
    logic [DW-1:0] or_m;
    logic          exp_pass;
    logic [AW-1:0] exp_faddr;
    logic [DW-1:0] exp_fdata;
    int            exp_done_n;
    int            exp_acc;
  } vec_t;

  vec_t vecs [5];

  task automatic run_vec(input vec_t v, input int mid_start);
    int n, err0;
    f_word = v.fword; f_and = v.and_m; f_or = v.or_m;
    err0   = trace_err;
    @(negedge clk);
    start_i  = 1'b1;
    run_base = acc_total;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 1;
    check({v.name, " cleared at first access"},
          64'({done_o, pass_o, fail_addr_o, fail_data_o, busy_o, ram_en_o}), 64'b11);
    while (!done_o && n < 400) begin
      start_i = (n == mid_start);
      @(posedge clk); #1;
      n++;
    end
    start_i = 1'b0;
    check({v.name, " done_o"}, 64'(done_o), 64'd1);
    check({v.name, " done cycle"}, 64'(n), 64'(v.exp_done_n));
    check({v.name, " pass_o"}, 64'(pass_o), 64'(v.exp_pass));
    check({v.name, " fail_addr_o"}, 64'(fail_addr_o), 64'(v.exp_faddr));
    check({v.name, " fail_data_o"}, 64'(fail_data_o), 64'(v.exp_fdata));
    check({v.name, " busy_o/ram_en_o"}, 64'({busy_o, ram_en_o}), 64'd0);
    check({v.name, " access count"}, 64'(acc_total - run_base), 64'(v.exp_acc));
    check({v.name, " trace errors"}, 64'(trace_err - err0), 64'd0);
    if (v.exp_pass) begin
      check({v.name, " M3 first addr"}, 64'(trace_addr[80]), 64'h3C);
      check({v.name, " M3 third addr"}, 64'(trace_addr[82]), 64'h38);
    end
  endtask

  initial begin
    vec_t pass_v;
    int   k;
    rst_i   = 1'b1;
    start_i = 1'b0;
    f_word  = -1;
    f_and   = '1;
    f_or    = '0;

    pass_v = '{"fault-free", -1, 32'hFFFF_FFFF, 32'h0, 1'b1, 6'h00, 32'h0, 162, 160};
    vecs[0] = pass_v;
    vecs[1] = '{"w5 b3 sa1", 5, 32'hFFFF_FFFF, 32'h0000_0008, 1'b0, 6'h14, 32'h0000_0008, 29, 28};
    vecs[2] = '{"restart after fail", -1, 32'hFFFF_FFFF, 32'h0, 1'b1, 6'h00, 32'h0, 162, 160};
    vecs[3] = '{"w15 b0 sa0", 15, 32'hFFFF_FFFE, 32'h0, 1'b0, 6'h3C, 32'hFFFF_FFFE, 81, 80};
    vecs[4] = '{"w0 b31 sa1", 0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 6'h00, 32'h8000_0000, 19, 18};

    repeat (2) @(negedge clk);
    #1;
    check("reset status", 64'({busy_o, done_o, pass_o, fail_addr_o, fail_data_o}), 64'd0);
    check("reset ram port", 64'({ram_en_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o}), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    check("idle after reset", 64'({busy_o, done_o, ram_en_o}), 64'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], 0);

    // start_i pulsed mid-run must not restart or disturb the test.
    pass_v.name = "mid-run start";
    run_vec(pass_v, 40);

    // Asynchronous reset during access 50.
    f_word = -1; f_and = '1; f_or = '0;
    @(negedge clk);
    start_i  = 1'b1;
    run_base = acc_total;
    @(negedge clk);
    start_i = 1'b0;
    k = 0;
    while ((acc_total - run_base) < 50 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    check("reached access 50", 64'(acc_total - run_base), 64'd50);
    check("busy before reset", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    #1;
    check("mid-run reset status", 64'({busy_o, done_o, pass_o, fail_addr_o, fail_data_o}), 64'd0);
    check("mid-run reset ram port", 64'({ram_en_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o}), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (4) @(negedge clk);
    check("idle after mid-run reset", 64'({busy_o, done_o, ram_en_o}), 64'd0);

    pass_v.name = "run after reset";
    run_vec(pass_v, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
